// File: rtl/imem_pkg.sv
// imem_pkg: loader FSM states and default geometry for the instruction memory.
// The optional parity bit is enabled by defining IMEM_PARITY_EN.
package imem_pkg;

    localparam int IMEM_DW = 32;
    localparam int IMEM_AW = 10;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// imem_array: single write port, registered read port storage.
// PW extra bits per word carry the optional parity (IMEM_PARITY_EN in the top).
module imem_array
    import imem_pkg::*;
#(
    parameter int DW = IMEM_DW,
    parameter int AW = IMEM_AW,
    parameter int PW = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DW+PW-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [DW+PW-1:0] rdata
);

    localparam int W     = DW + PW;
    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: instruction memory with a valid/ready streaming boot loader.
// Define IMEM_PARITY_EN to store and check even parity per word.
module instr_mem_loader
    import imem_pkg::*;
#(
    parameter int DW = IMEM_DW,
    parameter int AW = IMEM_AW
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          FETCH_EN,
    input  logic [AW-1:0] FETCH_ADDR,
    output logic [DW-1:0] FETCH_DATA,
    output logic          FETCH_VALID,
    output logic          STALL,
    input  logic          LOAD_START,
    input  logic [AW-1:0] LOAD_BASE,
    input  logic [AW:0]   LOAD_LEN,
    input  logic          LOAD_VALID,
    input  logic [DW-1:0] LOAD_DATA,
    output logic          LOAD_READY,
    output logic          LOAD_DONE,
    output logic          PARITY_ERR
);

`ifdef IMEM_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif

    imem_state_t state, nxt;

    logic [AW-1:0]    ptr;
    logic [AW:0]      cnt;
    logic             re;
    logic             beat;
    logic [DW+PW-1:0] wdata;
    logic [DW+PW-1:0] rdata;

    assign beat = LOAD_VALID & LOAD_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= RUN;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            RUN: begin
                if (LOAD_START) begin
                    nxt = (LOAD_LEN != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (beat && cnt == (AW+1)'(1)) begin
                    nxt = DONE;
                end
            end
            DONE:    nxt = RUN;
            default: nxt = RUN;
        endcase
    end

    always_comb begin
        re         = 1'b0;
        LOAD_READY = 1'b0;
        LOAD_DONE  = 1'b0;
        STALL      = 1'b0;
        unique case (state)
            RUN:  re = FETCH_EN;
            LOAD: begin
                LOAD_READY = 1'b1;
                STALL      = 1'b1;
            end
            DONE: begin
                LOAD_DONE = 1'b1;
                STALL     = 1'b1;
            end
            default: ;
        endcase
    end

    // A fetch in the same cycle as LOAD_START still completes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr         <= '0;
            cnt         <= '0;
            FETCH_VALID <= 1'b0;
        end else begin
            FETCH_VALID <= re;
            if (state == RUN && LOAD_START) begin
                ptr <= LOAD_BASE;
                cnt <= LOAD_LEN;
            end else if (beat) begin
                ptr <= ptr + AW'(1);
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end

`ifdef IMEM_PARITY_EN
    assign wdata      = {^LOAD_DATA, LOAD_DATA};
    assign PARITY_ERR = FETCH_VALID & (rdata[DW] ^ (^rdata[DW-1:0]));
`else
    assign wdata      = LOAD_DATA;
    assign PARITY_ERR = 1'b0;
`endif

    assign FETCH_DATA = rdata[DW-1:0];

    imem_array #(
        .DW (DW),
        .AW (AW),
        .PW (PW)
    ) u_array (
        .CLK   (CLK),
        .RST_N (RST_N),
        .we    (beat),
        .waddr (ptr),
        .wdata (wdata),
        .re    (re),
        .raddr (FETCH_ADDR),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed + randomized bench against an array model.
// Parity checks are compiled in when IMEM_PARITY_EN is defined.
module tb_instr_mem_loader;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          FETCH_EN = 1'b0;
    logic [AW-1:0] FETCH_ADDR = '0;
    logic [DW-1:0] FETCH_DATA;
    logic          FETCH_VALID;
    logic          STALL;
    logic          LOAD_START = 1'b0;
    logic [AW-1:0] LOAD_BASE = '0;
    logic [AW:0]   LOAD_LEN = '0;
    logic          LOAD_VALID = 1'b0;
    logic [DW-1:0] LOAD_DATA = '0;
    logic          LOAD_READY;
    logic          LOAD_DONE;
    logic          PARITY_ERR;

    instr_mem_loader #(.DW(DW), .AW(AW)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .FETCH_EN    (FETCH_EN),
        .FETCH_ADDR  (FETCH_ADDR),
        .FETCH_DATA  (FETCH_DATA),
        .FETCH_VALID (FETCH_VALID),
        .STALL       (STALL),
        .LOAD_START  (LOAD_START),
        .LOAD_BASE   (LOAD_BASE),
        .LOAD_LEN    (LOAD_LEN),
        .LOAD_VALID  (LOAD_VALID),
        .LOAD_DATA   (LOAD_DATA),
        .LOAD_READY  (LOAD_READY),
        .LOAD_DONE   (LOAD_DONE),
        .PARITY_ERR  (PARITY_ERR)
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_fd = '0;
    logic [DW-1:0] data_q [$];
    bit            pat_q [$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fetch_chk(input logic [AW-1:0] a);
        FETCH_EN   = 1'b1;
        FETCH_ADDR = a;
        tick();
        FETCH_EN = 1'b0;
        exp_fd   = ref_mem[a];
        chk("fetch_valid", FETCH_VALID, 1);
        chk("fetch_data", FETCH_DATA, exp_fd);
        chk("fetch_perr", PARITY_ERR, 0);
        chk("fetch_stall", STALL, 0);
    endtask

    task automatic fetch_burst(input int n);
        bit            en;
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            en         = bit'($urandom_range(1));
            a          = AW'($urandom);
            FETCH_EN   = en;
            FETCH_ADDR = a;
            tick();
            if (en) exp_fd = ref_mem[a];
            chk("burst_valid", FETCH_VALID, en);
            chk("burst_data", FETCH_DATA, exp_fd);
        end
        FETCH_EN = 1'b0;
    endtask

    // Words come from data_q; valid pattern from pat_q, else random gaps.
    task automatic do_load(input logic [AW-1:0] base, input int len,
                           input int gap_pct, input bit sfetch,
                           input bit extra_start);
        int            k;
        int            cyc;
        int            gaps;
        bit            v;
        logic [AW-1:0] fa;
        logic [AW-1:0] p;
        fa         = AW'($urandom);
        LOAD_START = 1'b1;
        LOAD_BASE  = base;
        LOAD_LEN   = (AW+1)'(len);
        FETCH_EN   = sfetch;
        FETCH_ADDR = fa;
        tick();
        LOAD_START = 1'b0;
        FETCH_EN   = 1'b0;
        if (sfetch) begin
            exp_fd = ref_mem[fa];
            chk("start_fetch_valid", FETCH_VALID, 1);
            chk("start_fetch_data", FETCH_DATA, exp_fd);
        end
        chk("stall_rise", STALL, 1);
        k = 0;
        cyc = 0;
        gaps = 0;
        while (k < len && cyc < 4 * len + 10) begin
            chk("load_ready", LOAD_READY, 1);
            if (pat_q.size() > 0) v = pat_q.pop_front();
            else v = ($urandom_range(99) >= gap_pct);
            LOAD_VALID = v;
            LOAD_DATA  = data_q[k];
            FETCH_EN   = bit'($urandom_range(1));
            FETCH_ADDR = AW'($urandom);
            if (extra_start && cyc == 1) begin
                LOAD_START = 1'b1;
                LOAD_BASE  = base + AW'(7);
                LOAD_LEN   = (AW+1)'(3);
            end
            tick();
            LOAD_START = 1'b0;
            LOAD_VALID = 1'b0;
            FETCH_EN   = 1'b0;
            if (v) begin
                p = base + AW'(k);
                ref_mem[p] = data_q[k];
                k++;
            end else begin
                gaps++;
            end
            cyc++;
            chk("load_fetch_ignored", FETCH_VALID, 0);
            chk("load_fetch_hold", FETCH_DATA, exp_fd);
            chk("load_stall", STALL, 1);
        end
        chk("load_beats", k, len);
        chk("load_cycles", cyc, len + gaps);
        chk("load_done", LOAD_DONE, 1);
        chk("done_ready", LOAD_READY, 0);
        chk("done_stall", STALL, 1);
        tick();
        chk("done_pulse_end", LOAD_DONE, 0);
        chk("stall_fall", STALL, 0);
        data_q.delete();
        pat_q.delete();
    endtask

    initial begin
        logic [AW-1:0] b;
        RST_N = 1'b0;
        #12;
        chk("rst_fetch_data", FETCH_DATA, 0);
        chk("rst_fetch_valid", FETCH_VALID, 0);
        chk("rst_stall", STALL, 0);
        chk("rst_load_ready", LOAD_READY, 0);
        chk("rst_load_done", LOAD_DONE, 0);
        chk("rst_perr", PARITY_ERR, 0);
        RST_N = 1'b1;
        tick();

        // Full-depth load: every word written once, base wraps.
        for (int i = 0; i < DEPTH; i++) data_q.push_back($urandom);
        do_load(AW'($urandom), DEPTH, 10, 1'b0, 1'b0);

        fetch_chk(AW'(5));
        tick();
        chk("fetch_idle_valid", FETCH_VALID, 0);
        chk("fetch_idle_hold", FETCH_DATA, exp_fd);
        fetch_burst(40);

        // Wrap-around load with valid held high.
        for (int i = 0; i < 4; i++) data_q.push_back(32'hA0 + 32'(i));
        do_load(AW'(10'h3FE), 4, 0, 1'b1, 1'b0);
        fetch_chk(AW'(10'h3FE));
        chk("wrap_a0", FETCH_DATA, 32'hA0);
        fetch_chk(AW'(10'h3FF));
        fetch_chk(AW'(10'h000));
        fetch_chk(AW'(10'h001));
        chk("wrap_a3", FETCH_DATA, 32'hA3);

        // Gapped valid pattern, with a stray LOAD_START mid-load.
        for (int i = 0; i < 3; i++) data_q.push_back($urandom);
        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        b = AW'($urandom);
        do_load(b, 3, 0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) fetch_chk(b + AW'(i));
        fetch_chk(b + AW'(7));

        // Zero-length load.
        b = AW'($urandom);
        do_load(b, 0, 0, 1'b1, 1'b0);
        fetch_chk(b);

        // Reset after 2 of 4 beats.
        b = AW'($urandom);
        LOAD_START = 1'b1;
        LOAD_BASE  = b;
        LOAD_LEN   = (AW+1)'(4);
        tick();
        LOAD_START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            LOAD_VALID = 1'b1;
            LOAD_DATA  = $urandom;
            tick();
            ref_mem[b + AW'(i)] = LOAD_DATA;
        end
        RST_N = 1'b0;
        #1;
        chk("mid_rst_stall", STALL, 0);
        chk("mid_rst_ready", LOAD_READY, 0);
        chk("mid_rst_done", LOAD_DONE, 0);
        chk("mid_rst_fdata", FETCH_DATA, 0);
        LOAD_VALID = 1'b0;
        exp_fd = '0;
        #2;
        RST_N = 1'b1;
        tick();
        chk("post_rst_stall", STALL, 0);
        chk("post_rst_ready", LOAD_READY, 0);
        for (int i = 0; i < 4; i++) fetch_chk(b + AW'(i));

        // Random loads interleaved with fetch bursts.
        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(20);
            for (int i = 0; i < len; i++) data_q.push_back($urandom);
            b = AW'($urandom);
            do_load(b, len, 30, 1'b1, bit'($urandom_range(1)));
            for (int i = 0; i < len; i++) fetch_chk(b + AW'(i));
            fetch_burst(20);
        end

`ifdef IMEM_PARITY_EN
        b = AW'($urandom);
        fetch_chk(b);
        dut.u_array.mem[b] = dut.u_array.mem[b] ^ 33'h1;
        FETCH_EN   = 1'b1;
        FETCH_ADDR = b;
        tick();
        FETCH_EN = 1'b0;
        chk("perr_valid", FETCH_VALID, 1);
        chk("perr_flag", PARITY_ERR, 1);
        chk("perr_data", FETCH_DATA, ref_mem[b] ^ 32'h1);
        fetch_chk(b + AW'(1));
        tick();
        chk("perr_idle", PARITY_ERR, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
